// File: rtl/ecap5_dwbintercon_pkg.sv
// Shared widths, target-index encoding and the stock BRAM/UART address map
// for the ecap5 single-master Wishbone interconnect.
package ecap5_dwbintercon_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  // Slaves occupy 0..NB_SLAVES-1, the internal default responder is NB_SLAVES,
  // and all-ones means nothing has been accepted in this bus cycle.
  typedef logic [3:0] target_t;

  localparam target_t NO_TARGET = 4'hF;

  function automatic target_t default_target(input int nb_slaves);
    return target_t'(nb_slaves);
  endfunction

  localparam logic [2*WB_ADDR_WIDTH-1:0] DEFAULT_SLAVE_BASE = {32'h0000_4000, 32'h0000_0000};
  localparam logic [2*WB_ADDR_WIDTH-1:0] DEFAULT_SLAVE_MASK = {32'hFFFF_C000, 32'hFFFF_C000};

endpackage

// File: rtl/ecap5_dwbintercon_decoder.sv
// Priority base/mask address decoder: lowest-index match wins, no match
// selects the default responder.
module ecap5_dwbintercon_decoder
  import ecap5_dwbintercon_pkg::*;
#(
  parameter int                                  NB_SLAVES  = 2,
  parameter logic [NB_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
  parameter logic [NB_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK
) (
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  output logic [NB_SLAVES-1:0]     sel_o,
  output target_t                  target_o
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_o    = '0;
    target_o = default_target(NB_SLAVES);
    // Walk from the highest index down so the lowest matching slave overwrites last.
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if ((adr_i & SLAVE_MASK[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
          SLAVE_BASE[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        target_o = target_t'(i);
      end
    end
  end

endmodule

// File: rtl/ecap5_dwbintercon.sv
// Single-master, N-slave pipelined Wishbone interconnect with in-order
// response routing and a default responder. Optional watchdog: ECAP5_DWBINTERCON_TIMEOUT_EN.
module ecap5_dwbintercon
  import ecap5_dwbintercon_pkg::*;
#(
  parameter int                                  NB_SLAVES       = 2,
  parameter logic [NB_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE      = DEFAULT_SLAVE_BASE,
  parameter logic [NB_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK      = DEFAULT_SLAVE_MASK,
  parameter int                                  MAX_OUTSTANDING = 4,
  parameter logic [WB_DATA_WIDTH-1:0]            UNMAPPED_DATA   = 32'h0,
  parameter int                                  TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,

  input  logic [WB_ADDR_WIDTH-1:0]           m_wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]           m_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]            m_wb_sel_i,
  input  logic                               m_wb_we_i,
  input  logic                               m_wb_stb_i,
  input  logic                               m_wb_cyc_i,
  output logic [WB_DATA_WIDTH-1:0]           m_wb_dat_o,
  output logic                               m_wb_ack_o,
  output logic                               m_wb_stall_o,

  output logic [NB_SLAVES*WB_ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [NB_SLAVES*WB_DATA_WIDTH-1:0] s_wb_dat_o,
  output logic [NB_SLAVES*WB_SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [NB_SLAVES-1:0]               s_wb_we_o,
  output logic [NB_SLAVES-1:0]               s_wb_stb_o,
  output logic [NB_SLAVES-1:0]               s_wb_cyc_o,
  input  logic [NB_SLAVES*WB_DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic [NB_SLAVES-1:0]               s_wb_ack_i,
  input  logic [NB_SLAVES-1:0]               s_wb_stall_i,

  output logic                               timeout_o
);

  localparam target_t    DFLT_TGT = default_target(NB_SLAVES);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);

  logic [NB_SLAVES-1:0] dec_sel;
  target_t              dec_tgt;

  logic [3:0]               count_q, count_d;
  target_t                  active_q, active_d;
  logic                     dflt_pend_q, dflt_pend_d;
  logic                     block, accept, dec_slave_stall;
  logic                     slave_ack, slave_ack_seen, to_ack, ack_seen;
  logic [WB_DATA_WIDTH-1:0] slave_dat;

  ecap5_dwbintercon_decoder #(
    .NB_SLAVES  (NB_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .adr_i    (m_wb_adr_i),
    .sel_o    (dec_sel),
    .target_o (dec_tgt)
  );

  // Stall of the decoded slave, and ack/data of the slave holding the bus.
  always_comb begin
    dec_slave_stall = 1'b0;
    slave_ack       = 1'b0;
    slave_dat       = UNMAPPED_DATA;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (dec_tgt == target_t'(i)) dec_slave_stall = s_wb_stall_i[i];
      if (active_q == target_t'(i)) begin
        slave_ack = s_wb_ack_i[i];
        slave_dat = s_wb_dat_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

  // Never mix slaves in flight: responses are routed purely by active_q.
  assign block          = (count_q == MAX_CNT) | ((count_q != '0) & (dec_tgt != active_q));
  assign m_wb_stall_o   = block | dec_slave_stall;
  assign accept         = m_wb_cyc_i & m_wb_stb_i & ~m_wb_stall_o;
  assign slave_ack_seen = (count_q != '0) & slave_ack;
  assign ack_seen       = m_wb_cyc_i & (slave_ack_seen | dflt_pend_q | to_ack);
  assign m_wb_ack_o     = ack_seen;
  assign m_wb_dat_o     = to_ack ? UNMAPPED_DATA : slave_dat;

  for (genvar i = 0; i < NB_SLAVES; i++) begin : g_slave
    assign s_wb_adr_o[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH] =
      m_wb_adr_i & ~SLAVE_MASK[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign s_wb_dat_o[i*WB_DATA_WIDTH +: WB_DATA_WIDTH] = m_wb_dat_i;
    assign s_wb_sel_o[i*WB_SEL_WIDTH +: WB_SEL_WIDTH]   = m_wb_sel_i;
    assign s_wb_we_o[i]  = m_wb_we_i;
    assign s_wb_stb_o[i] = m_wb_stb_i & dec_sel[i] & ~block;
    assign s_wb_cyc_o[i] = m_wb_cyc_i & (dec_sel[i] | (active_q == target_t'(i)));
  end

  always_comb begin
    count_d     = count_q;
    active_d    = active_q;
    dflt_pend_d = 1'b0;
    if (!m_wb_cyc_i) begin
      count_d  = '0;
      active_d = NO_TARGET;
    end else begin
      count_d     = count_q + 4'(accept) - 4'(ack_seen);
      dflt_pend_d = accept & (dec_tgt == DFLT_TGT);
      if (accept) active_d = dec_tgt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      active_q    <= NO_TARGET;
      dflt_pend_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      active_q    <= active_d;
      dflt_pend_q <= dflt_pend_d;
    end
  end

`ifdef ECAP5_DWBINTERCON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            real_ack;

  assign real_ack = slave_ack_seen | dflt_pend_q;
  // Fires on the TIMEOUT_CYCLES-th silent cycle after the last accept/ack.
  assign to_ack   = (count_q != '0) & ~real_ack & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d  = to_cnt_q + TO_W'(1);
    timeout_d = timeout_q | (m_wb_cyc_i & to_ack);
    if (!m_wb_cyc_i || real_ack || to_ack || (count_q == '0)) to_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign to_ack    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule
